matmul_seq: RTL and testbench

MATMUL_SEQ -- requirements
Module: matmul_seq

---
 rtl/matmul_pkg.sv | 28 ++
 rtl/matmul_mac.sv | 50 +++++
 rtl/matmul_seq.sv | 133 +++++++++++++
 tb/tb_matmul_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < value) result = b + 1;
    end
    return result;
  endfunction

  // Result width: full product plus growth from summing n products.
  function automatic int calc_rw(input int n, input int dw);
    return 2 * dw + clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate unit: extends one DW x DW product to RW and adds it to a cleared-able accumulator.
module matmul_mac #(
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int RW     = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [RW-1:0] sum
);

  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] b_ext;
  logic [2*DW-1:0] prod;
  logic [RW-1:0]   prod_ext;
  logic [RW-1:0]   acc;

  // The low 2*DW bits of the extended product are exact for both signed and unsigned operands.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{DW{a[DW-1]}}, a};
      b_ext = {{DW{b[DW-1]}}, b};
    end else begin
      a_ext = {{DW{1'b0}}, a};
      b_ext = {{DW{1'b0}}, b};
    end
    prod = a_ext * b_ext;
    if (SIGNED != 0) begin
      prod_ext = {{(RW-2*DW){prod[2*DW-1]}}, prod};
    end else begin
      prod_ext = {{(RW-2*DW){1'b0}}, prod};
    end
    sum = acc + prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiplier: one MAC per cycle through a single multiplier, result published atomically.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter  int N      = 3,
  parameter  int DW     = 8,
  parameter  int SIGNED = 0,
  localparam int RW     = calc_rw(N, DW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic              busy,
  output logic              done,
  output logic [N*N*RW-1:0] r_flat
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state;
  logic [CW-1:0]     i_cnt;
  logic [CW-1:0]     j_cnt;
  logic [CW-1:0]     k_cnt;
  logic [N*N*DW-1:0] a_reg;
  logic [N*N*DW-1:0] b_reg;
  logic [N*N*RW-1:0] staging;
  logic [N*N*RW-1:0] staging_next;
  logic [DW-1:0]     a_op;
  logic [DW-1:0]     b_op;
  logic [RW-1:0]     mac_sum;
  logic              last_k;
  logic              last_j;
  logic              last_i;
  logic              mac_clear;
  logic              mac_en;
  int                a_idx;
  int                b_idx;
  int                r_idx;

  assign last_k = (k_cnt == LAST);
  assign last_j = (j_cnt == LAST);
  assign last_i = (i_cnt == LAST);

  // Accumulator restarts on job acceptance and after each finished dot product.
  assign mac_en    = (state == RUN);
  assign mac_clear = ((state != RUN) && start) || ((state == RUN) && last_k);

  always_comb begin
    a_idx = (int'(i_cnt) * N + int'(k_cnt)) * DW;
    b_idx = (int'(k_cnt) * N + int'(j_cnt)) * DW;
    r_idx = (int'(i_cnt) * N + int'(j_cnt)) * RW;
    a_op  = a_reg[a_idx +: DW];
    b_op  = b_reg[b_idx +: DW];
    staging_next = staging;
    if (last_k) staging_next[r_idx +: RW] = mac_sum;
  end

  matmul_mac #(
    .DW     (DW),
    .SIGNED (SIGNED),
    .RW     (RW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (a_op),
    .b     (b_op),
    .sum   (mac_sum)
  );

  // r_flat is loaded from staging_next so the final element lands on the same edge as done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_flat  <= '0;
      i_cnt   <= '0;
      j_cnt   <= '0;
      k_cnt   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      staging <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a_flat;
            b_reg <= b_flat;
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          staging <= staging_next;
          if (last_k) begin
            k_cnt <= '0;
            if (last_j) begin
              j_cnt <= '0;
              i_cnt <= i_cnt + 1'b1;
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
          if (last_i && last_j && last_k) begin
            r_flat <= staging_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Randomized self-checking bench for matmul_seq: unsigned and signed instances against an integer reference model.
module tb_matmul_seq;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int RW = 2 * DW + 2;
  localparam int VW = N * N * DW;
  localparam int RV = N * N * RW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          use_signed;
  logic [VW-1:0] a_flat;
  logic [VW-1:0] b_flat;
  logic          start_u, start_s;
  logic          busy_u, busy_s, done_u, done_s;
  logic [RV-1:0] r_u, r_s;
  logic          busy_o, done_o;
  logic [RV-1:0] r_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [RV-1:0] last_u;

  always #5 clk = ~clk;

  assign start_u = start & ~use_signed;
  assign start_s = start & use_signed;
  assign busy_o  = use_signed ? busy_s : busy_u;
  assign done_o  = use_signed ? done_s : done_u;
  assign r_o     = use_signed ? r_s : r_u;

  matmul_seq #(.N(N), .DW(DW), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy_u), .done(done_u), .r_flat(r_u)
  );

  matmul_seq #(.N(N), .DW(DW), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy_s), .done(done_s), .r_flat(r_s)
  );

  function automatic longint elem(input logic [VW-1:0] m, input int idx, input bit sgn);
    logic [DW-1:0] e;
    e = m[idx*DW +: DW];
    if (sgn) return longint'($signed(e));
    return longint'(e);
  endfunction

  function automatic logic [RV-1:0] ref_mul(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit sgn);
    logic [RV-1:0] res;
    longint s;
    res = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += elem(a, i*N+k, sgn) * elem(b, k*N+j, sgn);
        res[(i*N+j)*RW +: RW] = s[RW-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [VW-1:0] rand_mat();
    logic [VW-1:0] m;
    for (int idx = 0; idx < N*N; idx++) m[idx*DW +: DW] = DW'($urandom_range(0, 255));
    return m;
  endfunction

  function automatic logic [VW-1:0] fill_mat(input logic [DW-1:0] v);
    logic [VW-1:0] m;
    for (int idx = 0; idx < N*N; idx++) m[idx*DW +: DW] = v;
    return m;
  endfunction

  function automatic logic [VW-1:0] identity_mat();
    logic [VW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = DW'(1);
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [RV-1:0] observed, input logic [RV-1:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [VW-1:0] a, input logic [VW-1:0] b);
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // lat is the index of the cycle showing done, counting the cycle after the accepting edge as 1.
  task automatic wait_done(input int already, output int lat);
    int cnt;
    cnt = already;
    lat = 0;
    while (cnt < 200 && lat == 0) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done_o) lat = cnt + 1;
    end
    if (lat == 0) checkOutput("done_timeout", RV'(0), RV'(1));
  endtask

  task automatic run_and_check(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b);
    int lat;
    logic [RV-1:0] exp_r;
    exp_r = ref_mul(a, b, use_signed);
    applyStimulus(a, b);
    checkOutput({tag, "_busy_run"}, RV'(busy_o), RV'(1));
    wait_done(0, lat);
    checkOutput({tag, "_latency"}, RV'(lat), RV'(N*N*N + 1));
    checkOutput({tag, "_r"}, r_o, exp_r);
    checkOutput({tag, "_busy_at_done"}, RV'(busy_o), RV'(0));
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, RV'(done_o), RV'(0));
    checkOutput({tag, "_r_hold"}, r_o, exp_r);
    if (!use_signed) last_u = exp_r;
  endtask

  initial begin
    logic [VW-1:0] a1, b1, a2, b2, seq_b;
    logic [RV-1:0] seq_r, neg1_r;
    int lat, cnt;

    rst_n = 1'b0;
    start = 1'b0;
    use_signed = 1'b0;
    a_flat = '0;
    b_flat = '0;
    last_u = '0;
    #12;
    checkOutput("reset_busy_u", RV'(busy_u), RV'(0));
    checkOutput("reset_done_u", RV'(done_u), RV'(0));
    checkOutput("reset_r_u", r_u, RV'(0));
    checkOutput("reset_r_s", r_s, RV'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int idx = 0; idx < N*N; idx++) begin
      seq_b[idx*DW +: DW] = DW'(idx + 1);
      seq_r[idx*RW +: RW] = RW'(idx + 1);
    end
    run_and_check("ident", identity_mat(), seq_b);
    checkOutput("ident_const", r_o, seq_r);

    run_and_check("all255", fill_mat(8'hFF), fill_mat(8'hFF));
    checkOutput("all255_r00", RV'(r_o[0 +: RW]), RV'(195075));
    checkOutput("all255_r22", RV'(r_o[8*RW +: RW]), RV'(195075));

    for (int t = 0; t < 5; t++) run_and_check("rand_u", rand_mat(), rand_mat());

    use_signed = 1'b1;
    run_and_check("neg128", fill_mat(8'h80), fill_mat(8'h80));
    checkOutput("neg128_r11", RV'(r_o[4*RW +: RW]), RV'(49152));
    run_and_check("neg1", fill_mat(8'hFF), identity_mat());
    for (int idx = 0; idx < N*N; idx++) neg1_r[idx*RW +: RW] = {RW{1'b1}};
    checkOutput("neg1_const", r_o, neg1_r);
    for (int t = 0; t < 5; t++) run_and_check("rand_s", rand_mat(), rand_mat());

    // A start during RUN carrying new operands must not disturb the job.
    use_signed = 1'b0;
    a1 = rand_mat();
    b1 = rand_mat();
    applyStimulus(a1, b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ignore_r_hold", r_o, last_u);
    a_flat = rand_mat();
    b_flat = rand_mat();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignore_busy", RV'(busy_o), RV'(1));
    wait_done(5, lat);
    checkOutput("ignore_latency", RV'(lat), RV'(N*N*N + 1));
    checkOutput("ignore_r", r_o, ref_mul(a1, b1, 1'b0));
    last_u = ref_mul(a1, b1, 1'b0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) cnt++;
    end
    checkOutput("ignore_single_done", RV'(cnt), RV'(0));

    // Reset in the middle of a job.
    applyStimulus(rand_mat(), rand_mat());
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", RV'(busy_o), RV'(0));
    checkOutput("abort_done", RV'(done_o), RV'(0));
    checkOutput("abort_r", r_o, RV'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) cnt++;
    end
    checkOutput("abort_no_done", RV'(cnt), RV'(0));
    run_and_check("after_abort", rand_mat(), rand_mat());

    // start held high through DONE launches a second job back-to-back.
    a1 = rand_mat();
    b1 = rand_mat();
    a2 = rand_mat();
    b2 = rand_mat();
    a_flat = a1;
    b_flat = b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(0, lat);
    checkOutput("b2b_latency1", RV'(lat), RV'(N*N*N + 1));
    checkOutput("b2b_r1", r_o, ref_mul(a1, b1, 1'b0));
    a_flat = a2;
    b_flat = b2;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_busy", RV'(busy_o), RV'(1));
    checkOutput("b2b_r1_hold", r_o, ref_mul(a1, b1, 1'b0));
    wait_done(0, lat);
    checkOutput("b2b_gap", RV'(lat), RV'(N*N*N + 1));
    checkOutput("b2b_r2", r_o, ref_mul(a2, b2, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
